string_byte_assembler: RTL and testbench

STRING_BYTE_ASSEMBLER -- requirements
Module: string_byte_assembler

---
 rtl/string_stage_pkg.sv | 32 +++
 rtl/string_byte_assembler.sv | 126 ++++++++++++
 tb/tb_string_byte_assembler.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/string_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : string_stage_pkg
//  Purpose  : Shared definitions for the string byte assembler and the
//             downstream string-method stage that consumes its output.
//  Contents : state_e          - assembler FSM states (COLLECT, HOLD)
//             DEFAULT_MAX_LEN  - default character capacity per string
//             NUL_BYTE         - in-band string terminator
//             is_terminator()  - true when an accepted beat ends a string
//  Revision : 1.0 - initial release
// ============================================================================
package string_stage_pkg;

  // Default maximum characters retained per assembled string.
  localparam int DEFAULT_MAX_LEN = 16;

  // A NUL byte ends a string and is never stored.
  localparam logic [7:0] NUL_BYTE = 8'h00;

  // Assembler state machine encoding, explicit 1-bit width.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  // A beat terminates the current string if it carries NUL or is flagged last.
  function automatic logic is_terminator(input logic [7:0] b, input logic last);
    return (b == NUL_BYTE) || last;
  endfunction

endpackage : string_stage_pkg
`default_nettype wire

// File: rtl/string_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : string_byte_assembler
//  Purpose  : Collects a byte stream into a string. A string ends on a beat
//             with in_last set or on a NUL byte; the finished string is then
//             held on the output until downstream accepts it. Characters
//             beyond MAX_LEN are dropped and flagged.
//  Ports    : clk          - clock, all state updates on rising edge
//             rst          - synchronous active-high reset
//             in_valid     - input byte present
//             in_ready     - block accepts a byte this cycle (COLLECT)
//             in_byte      - character to append
//             in_last      - accepted byte terminates the string
//             out_valid    - assembled string available (HOLD)
//             out_ready    - downstream consumes the string
//             out_string   - assembled string (partial while collecting)
//             out_len      - character count of out_string
//             out_overflow - bytes were dropped at MAX_LEN
//             out_count    - strings delivered since reset (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module string_byte_assembler
  import string_stage_pkg::*;
#(
  parameter int MAX_LEN = DEFAULT_MAX_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output string       out_string,
  output int          out_len,
  output logic        out_overflow,
  output logic [15:0] out_count
);

  state_e      state_q, state_d;
  string       buf_q, buf_d;
  int          len_q, len_d;
  logic        ovf_q, ovf_d;
  logic [15:0] count_q, count_d;

  logic w_accept;
  logic w_deliver;
  logic w_is_nul;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);

  assign w_accept  = in_valid && in_ready;
  assign w_deliver = out_valid && out_ready;
  assign w_is_nul  = (in_byte == NUL_BYTE);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    count_d = count_q;

    case (state_q)
      COLLECT: begin
        if (w_accept) begin
          // NUL is a terminator only; every other byte is a character,
          // including the one carried on the last beat.
          if (!w_is_nul) begin
            if (len_q < MAX_LEN) begin
              buf_d = $sformatf("%s%c", buf_q, in_byte);
              len_d = len_q + 1;
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (is_terminator(in_byte, in_last)) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        // Outputs stay frozen until the handshake; the buffer is then
        // cleared so the next string starts empty. No input beat is taken
        // in this cycle because in_ready is low throughout HOLD.
        if (w_deliver) begin
          buf_d   = "";
          len_d   = 0;
          ovf_d   = 1'b0;
          count_d = count_q + 16'd1;
          state_d = COLLECT;
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Any pending or partial string is discarded without counting it.
      state_q <= COLLECT;
      buf_q   <= "";
      len_q   <= 0;
      ovf_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign out_string   = buf_q;
  assign out_len      = len_q;
  assign out_overflow = ovf_q;
  assign out_count    = count_q;

endmodule : string_byte_assembler
`default_nettype wire

// File: tb/tb_string_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_string_byte_assembler
//  Purpose  : Directed bench for string_byte_assembler (MAX_LEN = 4). The
//             stimulus process pushes the expected string for every
//             terminated input sequence; a monitor pops and compares on each
//             output handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_string_byte_assembler;

  localparam int TB_MAX_LEN = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  string       out_string;
  int          out_len;
  logic        out_overflow;
  logic [15:0] out_count;

  string_byte_assembler #(.MAX_LEN(TB_MAX_LEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_byte      (in_byte),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_string   (out_string),
    .out_len      (out_len),
    .out_overflow (out_overflow),
    .out_count    (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string s;
    int    len;
    bit    ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_count;
  int   n_vec;
  int   n_err;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input string act, input string exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic push_exp(input string s, input int len, input bit ovf);
    exp_t e;
    e.s   = s;
    e.len = len;
    e.ovf = ovf;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; the beat is accepted at the next edge.
  task automatic beat(input logic [7:0] b, input logic last);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input logic nul_term);
    for (int i = 0; i < s.len(); i++) begin
      beat(s[i], (!nul_term) && (i == s.len() - 1));
    end
    if (nul_term) beat(8'h00, 1'b0);
  endtask

  // One cycle after the terminating beat: output must be presented, then
  // the handshake edge passes and the block is back in COLLECT.
  task automatic expect_delivery(input string tag);
    @(negedge clk);
    chk({tag, "_valid_latency"}, int'(out_valid), 1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: compares on every output handshake.
  always @(negedge clk) begin
    if (rst) begin
      mon_count = 0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got \"%s\" expected none", out_string);
      end else begin
        mon_e = sb.pop_front();
        chks("out_string", out_string, mon_e.s);
        chk("out_len", out_len, mon_e.len);
        chk("out_overflow", int'(out_overflow), int'(mon_e.ovf));
        chk("out_count", int'(out_count), mon_count);
        mon_count = mon_count + 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    mon_count = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_out_overflow", int'(out_overflow), 0);
    chk("rst_out_count", int'(out_count), 0);
    chks("rst_out_string", out_string, "");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    // Plain three-character string
    push_exp("abc", 3, 1'b0);
    send_str("abc", 1'b0);
    expect_delivery("abc");

    // Overflow: only the first MAX_LEN characters survive
    push_exp("abcd", 4, 1'b1);
    send_str("abcdef", 1'b0);
    expect_delivery("abcdef");

    // Exactly MAX_LEN characters: no overflow
    push_exp("wxyz", 4, 1'b0);
    send_str("wxyz", 1'b0);
    expect_delivery("wxyz");

    // NUL termination; partial buffer visible while collecting
    push_exp("x", 1, 1'b0);
    beat("x", 1'b0);
    @(negedge clk);
    chk("partial_len", out_len, 1);
    chk("partial_valid", int'(out_valid), 0);
    @(posedge clk); #1;
    beat(8'h00, 1'b0);
    expect_delivery("nul");

    // Single NUL with last: empty string
    push_exp("", 0, 1'b0);
    beat(8'h00, 1'b1);
    @(negedge clk);
    chk("empty_valid", int'(out_valid), 1);
    chk("empty_len", out_len, 0);
    @(posedge clk); #1;

    // Backpressure: outputs frozen, input refused
    out_ready = 1'b0;
    push_exp("ok", 2, 1'b0);
    send_str("ok", 1'b0);
    in_valid = 1'b1;
    in_byte  = "Z";
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_valid", int'(out_valid), 1);
      chks("hold_string", out_string, "ok");
      chk("hold_len", out_len, 2);
      @(posedge clk); #1;
    end
    chk("hold_count_before", int'(out_count), 5);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_count_after", int'(out_count), 6);
    chk("hold_in_ready_after", int'(in_ready), 1);
    @(posedge clk); #1;

    // Reset while holding discards the string
    out_ready = 1'b0;
    send_str("hi", 1'b0);
    @(negedge clk);
    chk("hi_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_hold_valid", int'(out_valid), 0);
    chk("rst_hold_len", out_len, 0);
    chk("rst_hold_count", int'(out_count), 0);
    chk("rst_hold_in_ready", int'(in_ready), 1);
    chks("rst_hold_string", out_string, "");
    @(posedge clk); #1;
    out_ready = 1'b1;

    // Counting restarts from zero after reset
    push_exp("ab", 2, 1'b0);
    send_str("ab", 1'b0);
    expect_delivery("ab");
    @(negedge clk);
    chk("final_count", int'(out_count), 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_string_byte_assembler
`default_nettype wire
